// File: rtl/wb_mem_tester_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : mem_tester_pkg
// Purpose : Shared types and constants for the Wishbone memory tester.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
package mem_tester_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Per-word bus phase: request (stb), wait for ack, then one idle cycle.
   typedef enum logic [1:0] {
      PH_REQ  = 2'd0,
      PH_WAIT = 2'd1,
      PH_GAP  = 2'd2
   } phase_t;

   localparam logic [2:0] c_reg_ctrl      = 3'd0;
   localparam logic [2:0] c_reg_status    = 3'd1;
   localparam logic [2:0] c_reg_base      = 3'd2;
   localparam logic [2:0] c_reg_len       = 3'd3;
   localparam logic [2:0] c_reg_seed      = 3'd4;
   localparam logic [2:0] c_reg_err_cnt   = 3'd5;
   localparam logic [2:0] c_reg_first_err = 3'd6;
   localparam logic [2:0] c_reg_cycles    = 3'd7;

   localparam logic [31:0] c_lfsr_poly = 32'h8020_0003;

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? c_lfsr_poly : 32'h0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mem_tester_lfsr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : lfsr32_galois
// Purpose : 32-bit Galois LFSR pattern source; a zero seed loads as 1.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
module lfsr32_galois (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_advance,
   input  logic [31:0] i_seed,
   output logic [31:0] o_value
);
   import mem_tester_pkg::*;

   logic [31:0] r_value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= '0;
      end else if (i_load) begin
         r_value <= (i_seed == 32'h0) ? 32'h1 : i_seed;
      end else if (i_advance) begin
         r_value <= lfsr_next(r_value);
      end
   end

   assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/wb_mem_tester.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : wb_mem_tester
// Purpose : Writes an LFSR pattern to memory over a Wishbone master, reads it
//           back and compares; controlled through a small Wishbone slave.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
module wb_mem_tester #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  wbs_adr,
   input  logic [31:0] wbs_dat_w,
   output logic [31:0] wbs_dat_r,
   input  logic        wbs_cyc,
   input  logic        wbs_stb,
   input  logic        wbs_we,
   output logic        wbs_ack,
   output logic        wbs_stall,
   output logic        wbs_err,
   output logic [31:0] wbm_adr,
   output logic [31:0] wbm_dat_w,
   input  logic [31:0] wbm_dat_r,
   output logic [3:0]  wbm_sel,
   output logic        wbm_cyc,
   output logic        wbm_stb,
   output logic        wbm_we,
   input  logic        wbm_ack,
   input  logic        wbm_stall,
   input  logic        wbm_err,
   output logic        done_irq
);
   import mem_tester_pkg::*;

   state_t      r_state, w_state_nxt;
   phase_t      r_phase, w_phase_nxt;

   logic [31:0] r_base, r_len, r_seed;
   logic [31:0] r_err_cnt, r_first_err_addr, r_cycles;
   logic        r_done, r_pass, r_bus_err, r_abort_req;
   logic [31:0] r_idx, r_addr, r_tmo;
   logic        r_ack;
   logic [31:0] r_dat_r;

   logic        w_busy, w_req, w_wr, w_start, w_abort, w_last, w_timeout, w_cyc;
   logic        w_word_done, w_mismatch, w_bus_fail, w_enter_done, w_enter_read;
   logic        w_pass_now;
   logic [31:0] w_pattern, w_rd_mux;

   assign w_busy    = (r_state == ST_WRITE) || (r_state == ST_READ);
   assign w_cyc     = w_busy && (r_phase != PH_GAP);
   assign w_req     = wbs_cyc & wbs_stb;
   assign w_wr      = w_req & wbs_we;
   assign w_start   = w_wr && (wbs_adr == c_reg_ctrl) && wbs_dat_w[0] && (r_state == ST_IDLE);
   assign w_abort   = w_wr && (wbs_adr == c_reg_ctrl) && wbs_dat_w[1] && w_busy;
   assign w_last    = (r_idx + 32'd1) == r_len;
   assign w_timeout = w_cyc && (r_tmo == 32'(TIMEOUT_CYCLES - 1));

   lfsr32_galois u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_start | w_enter_read),
      .i_advance (w_word_done),
      .i_seed    (r_seed),
      .o_value   (w_pattern)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_phase <= PH_REQ;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_word_done = 1'b0;
      w_mismatch  = 1'b0;
      w_bus_fail  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_phase_nxt = PH_REQ;
               w_state_nxt = (r_len == 32'h0) ? ST_DONE : ST_WRITE;
            end
         end
         ST_WRITE, ST_READ: begin
            case (r_phase)
               PH_REQ: begin
                  if (wbm_err || w_timeout) begin
                     w_bus_fail  = 1'b1;
                     w_state_nxt = ST_DONE;
                  end else if (!wbm_stall) begin
                     w_phase_nxt = PH_WAIT;
                  end
               end
               PH_WAIT: begin
                  if (wbm_err || w_timeout) begin
                     w_bus_fail  = 1'b1;
                     w_state_nxt = ST_DONE;
                  end else if (wbm_ack) begin
                     w_word_done = 1'b1;
                     w_mismatch  = (r_state == ST_READ) && (wbm_dat_r != w_pattern);
                     w_phase_nxt = PH_GAP;
                     if (r_abort_req || w_abort) begin
                        w_state_nxt = ST_DONE;
                     end else if (w_last) begin
                        w_state_nxt = (r_state == ST_WRITE) ? ST_READ : ST_DONE;
                     end
                  end
               end
               default: begin
                  // Abort takes effect here only when nothing is outstanding.
                  if (r_abort_req || w_abort) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_phase_nxt = PH_REQ;
                  end
               end
            endcase
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_phase_nxt = PH_REQ;
         end
      endcase
   end

   assign w_enter_done = (r_state != ST_DONE) && (w_state_nxt == ST_DONE);
   assign w_enter_read = (r_state == ST_WRITE) && (w_state_nxt == ST_READ);
   assign w_pass_now   = (r_err_cnt == 32'h0) && !w_mismatch && !r_bus_err && !w_bus_fail
                         && !r_abort_req && !w_abort;

   always_comb begin
      w_rd_mux = 32'h0;
      case (wbs_adr)
         c_reg_status:    w_rd_mux = {28'h0, r_bus_err, r_pass, r_done, w_busy};
         c_reg_base:      w_rd_mux = r_base;
         c_reg_len:       w_rd_mux = r_len;
         c_reg_seed:      w_rd_mux = r_seed;
         c_reg_err_cnt:   w_rd_mux = r_err_cnt;
         c_reg_first_err: w_rd_mux = r_first_err_addr;
         c_reg_cycles:    w_rd_mux = r_cycles;
         default:         w_rd_mux = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base           <= '0;
         r_len            <= '0;
         r_seed           <= '0;
         r_err_cnt        <= '0;
         r_first_err_addr <= '0;
         r_cycles         <= '0;
         r_done           <= 1'b0;
         r_pass           <= 1'b0;
         r_bus_err        <= 1'b0;
         r_abort_req      <= 1'b0;
         r_idx            <= '0;
         r_addr           <= '0;
         r_tmo            <= '0;
         r_ack            <= 1'b0;
         r_dat_r          <= '0;
      end else begin
         r_ack <= w_req;
         if (w_req) begin
            r_dat_r <= w_rd_mux;
         end
         if (w_wr && !w_busy) begin
            case (wbs_adr)
               c_reg_base: r_base <= {wbs_dat_w[31:2], 2'b00};
               c_reg_len:  r_len  <= wbs_dat_w;
               c_reg_seed: r_seed <= wbs_dat_w;
               default:    ;
            endcase
         end

         if (w_cyc && (w_state_nxt == r_state) && (w_phase_nxt != PH_GAP)) begin
            r_tmo <= r_tmo + 32'd1;
         end else begin
            r_tmo <= '0;
         end

         if (w_busy && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
         end

         if (w_start) begin
            r_idx            <= '0;
            r_addr           <= r_base;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_cycles         <= '0;
            r_bus_err        <= 1'b0;
            r_abort_req      <= 1'b0;
            // An empty run finishes immediately and trivially passes.
            r_done           <= (r_len == 32'h0);
            r_pass           <= (r_len == 32'h0);
         end else begin
            if (w_enter_read) begin
               r_idx  <= '0;
               r_addr <= r_base;
            end else if (w_word_done) begin
               r_idx  <= r_idx + 32'd1;
               r_addr <= r_addr + 32'd4;
            end
            if (w_abort) begin
               r_abort_req <= 1'b1;
            end
            if (w_bus_fail) begin
               r_bus_err <= 1'b1;
            end
            if (w_mismatch) begin
               if (r_err_cnt != 32'hFFFF_FFFF) begin
                  r_err_cnt <= r_err_cnt + 32'd1;
               end
               if (r_err_cnt == 32'h0) begin
                  r_first_err_addr <= r_addr;
               end
            end
            if (w_enter_done) begin
               r_done <= 1'b1;
               r_pass <= w_pass_now;
            end
         end
      end
   end

   assign wbs_ack   = r_ack;
   assign wbs_dat_r = r_dat_r;
   assign wbs_stall = 1'b0;
   assign wbs_err   = 1'b0;
   assign wbm_adr   = r_addr;
   assign wbm_dat_w = w_pattern;
   assign wbm_sel   = 4'hF;
   assign wbm_cyc   = w_cyc;
   assign wbm_stb   = w_busy && (r_phase == PH_REQ);
   assign wbm_we    = w_cyc && (r_state == ST_WRITE);
   assign done_irq  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_tester.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_wb_mem_tester
// Purpose : Directed self-checking bench for wb_mem_tester with a memory model.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
module tb_wb_mem_tester;

   localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_BASE = 3'd2, A_LEN = 3'd3;
   localparam logic [2:0] A_SEED = 3'd4, A_ERRC = 3'd5, A_FIRST = 3'd6, A_CYC = 3'd7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  wbs_adr;
   logic [31:0] wbs_dat_w, wbs_dat_r;
   logic        wbs_cyc, wbs_stb, wbs_we, wbs_ack, wbs_stall, wbs_err;
   logic [31:0] wbm_adr, wbm_dat_w, wbm_dat_r;
   logic [3:0]  wbm_sel;
   logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack, wbm_stall, wbm_err;
   logic        done_irq;

   always #5 clk = ~clk;

   wb_mem_tester #(.TIMEOUT_CYCLES(16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wbs_adr   (wbs_adr),
      .wbs_dat_w (wbs_dat_w),
      .wbs_dat_r (wbs_dat_r),
      .wbs_cyc   (wbs_cyc),
      .wbs_stb   (wbs_stb),
      .wbs_we    (wbs_we),
      .wbs_ack   (wbs_ack),
      .wbs_stall (wbs_stall),
      .wbs_err   (wbs_err),
      .wbm_adr   (wbm_adr),
      .wbm_dat_w (wbm_dat_w),
      .wbm_dat_r (wbm_dat_r),
      .wbm_sel   (wbm_sel),
      .wbm_cyc   (wbm_cyc),
      .wbm_stb   (wbm_stb),
      .wbm_we    (wbm_we),
      .wbm_ack   (wbm_ack),
      .wbm_stall (wbm_stall),
      .wbm_err   (wbm_err),
      .done_irq  (done_irq)
   );

   int n_vec = 0;
   int n_mis = 0;

   // Slave model configuration (driven by the stimulus process only).
   bit          sl_noack = 1'b0;
   bit          sl_corrupt = 1'b0;
   logic [31:0] sl_corrupt_adr = 32'h0;

   // Monitor state (written by the model process only).
   logic [31:0] mem [logic [31:0]];
   logic [31:0] wlog_adr [$];
   logic [31:0] wlog_dat [$];
   int n_irq = 0, n_cyc = 0, n_req = 0, n_ack = 0, n_unstable = 0, n_stallcyc = 0;
   bit          have_prev = 1'b0;
   logic [64:0] prev_req = '0;

   always @(posedge clk) begin
      logic [31:0] rd;
      wbm_ack <= 1'b0;
      if (wbm_cyc && wbm_stb && !wbm_stall) begin
         n_req++;
         if (wbm_we) begin
            mem[wbm_adr] = wbm_dat_w;
            wlog_adr.push_back(wbm_adr);
            wlog_dat.push_back(wbm_dat_w);
         end else begin
            rd = mem.exists(wbm_adr) ? mem[wbm_adr] : 32'h0;
            if (sl_corrupt && (wbm_adr == sl_corrupt_adr)) rd = rd ^ 32'h1;
            wbm_dat_r <= rd;
         end
         if (!sl_noack) wbm_ack <= 1'b1;
      end
      if (wbm_cyc) n_cyc++;
      if (wbm_cyc && wbm_ack) n_ack++;
      if (done_irq) n_irq++;
      if (wbm_stb && wbm_stall) begin
         n_stallcyc++;
         if (have_prev && (prev_req != {wbm_adr, wbm_dat_w, wbm_we})) n_unstable++;
         prev_req  = {wbm_adr, wbm_dat_w, wbm_we};
         have_prev = 1'b1;
      end else begin
         have_prev = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic wbs_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_adr = a; wbs_dat_w = d;
      @(negedge clk);
      wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
   endtask

   task automatic wbs_read(input logic [2:0] a, output logic [31:0] d, output logic ak);
      @(negedge clk);
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = a;
      @(negedge clk);
      wbs_cyc = 1'b0; wbs_stb = 1'b0;
      d  = wbs_dat_r;
      ak = wbs_ack;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        ak;
      wbs_read(a, d, ak);
      chk(tag, d, exp);
   endtask

   task automatic wait_done(input int limit);
      bit seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (done_irq) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) chk("done_wait_timeout", 32'h0, 32'h1);
      repeat (3) @(negedge clk);
   endtask

   task automatic setup(input logic [31:0] seed, input logic [31:0] base, input logic [31:0] len);
      wbs_write(A_SEED, seed);
      wbs_write(A_BASE, base);
      wbs_write(A_LEN, len);
   endtask

   initial begin
      int          w0, irq0, cyc0, req0, ack0, unst0, stl0;
      logic [31:0] d;
      logic        ak;
      logic [31:0] exp_d [3];
      bit          seen;

      rst_n = 1'b0;
      wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0; wbs_adr = '0; wbs_dat_w = '0;
      wbm_stall = 1'b0; wbm_err = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      chk("rst_cyc", {31'h0, wbm_cyc}, 32'h0);
      chk("rst_irq", {31'h0, done_irq}, 32'h0);
      chk("rst_sel", {28'h0, wbm_sel}, 32'hF);
      wbs_read(A_STATUS, d, ak);
      chk("rst_status", d, 32'h0);
      chk("wbs_ack", {31'h0, ak}, 32'h1);

      // Basic pass: seed 1, two words, BASE low bits masked
      setup(32'h1, 32'h4000_0003, 32'd2);
      rd_chk("base_mask", A_BASE, 32'h4000_0000);
      w0 = wlog_adr.size(); irq0 = n_irq;
      wbs_write(A_CTRL, 32'h1);
      wait_done(200);
      chk("t1_nwr", wlog_adr.size() - w0, 32'd2);
      if (wlog_adr.size() >= w0 + 2) begin
         chk("t1_adr0", wlog_adr[w0],     32'h4000_0000);
         chk("t1_dat0", wlog_dat[w0],     32'h0000_0001);
         chk("t1_adr1", wlog_adr[w0 + 1], 32'h4000_0004);
         chk("t1_dat1", wlog_dat[w0 + 1], 32'h8020_0003);
      end
      rd_chk("t1_status", A_STATUS, 32'h6);
      rd_chk("t1_errcnt", A_ERRC, 32'h0);
      rd_chk("t1_cycles", A_CYC, 32'd11);
      rd_chk("t1_ctrl_rd", A_CTRL, 32'h0);
      chk("t1_irq", n_irq - irq0, 32'd1);

      // Read-back mismatch on word 1
      sl_corrupt = 1'b1; sl_corrupt_adr = 32'h4000_0004;
      wbs_write(A_CTRL, 32'h1);
      wait_done(200);
      sl_corrupt = 1'b0;
      rd_chk("t2_errcnt", A_ERRC, 32'h1);
      rd_chk("t2_first", A_FIRST, 32'h4000_0004);
      rd_chk("t2_status", A_STATUS, 32'h2);

      // Stall held for 5 cycles on the first request
      setup(32'h1234_5678, 32'h0000_0100, 32'd3);
      wbm_stall = 1'b1;
      w0 = wlog_adr.size(); unst0 = n_unstable; stl0 = n_stallcyc;
      wbs_write(A_CTRL, 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (wbm_stb) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) chk("t3_stb_wait_timeout", 32'h0, 32'h1);
      repeat (5) @(negedge clk);
      wbm_stall = 1'b0;
      wait_done(200);
      exp_d = '{32'h1234_5678, 32'h091A_2B3C, 32'h048D_159E};
      chk("t3_nwr", wlog_adr.size() - w0, 32'd3);
      if (wlog_adr.size() >= w0 + 3) begin
         for (int k = 0; k < 3; k++) begin
            chk("t3_adr", wlog_adr[w0 + k], 32'h100 + 32'(4 * k));
            chk("t3_dat", wlog_dat[w0 + k], exp_d[k]);
         end
      end
      chk("t3_stall_seen", 32'((n_stallcyc - stl0) >= 5), 32'h1);
      chk("t3_unstable", n_unstable - unst0, 32'd0);
      rd_chk("t3_status", A_STATUS, 32'h6);

      // Zero seed and address wrap-around
      setup(32'h0, 32'hFFFF_FFFC, 32'd2);
      w0 = wlog_adr.size();
      wbs_write(A_CTRL, 32'h1);
      wait_done(200);
      if (wlog_adr.size() >= w0 + 2) begin
         chk("t4_adr0", wlog_adr[w0],     32'hFFFF_FFFC);
         chk("t4_dat0", wlog_dat[w0],     32'h0000_0001);
         chk("t4_adr1", wlog_adr[w0 + 1], 32'h0000_0000);
         chk("t4_dat1", wlog_dat[w0 + 1], 32'h8020_0003);
      end else begin
         chk("t4_nwr", wlog_adr.size() - w0, 32'd2);
      end
      rd_chk("t4_status", A_STATUS, 32'h6);

      // Timeout: no ack ever
      setup(32'h1, 32'h0000_0200, 32'd4);
      sl_noack = 1'b1;
      cyc0 = n_cyc;
      wbs_write(A_CTRL, 32'h1);
      wait_done(200);
      sl_noack = 1'b0;
      rd_chk("t5_status", A_STATUS, 32'hA);
      chk("t5_cyc_cycles", n_cyc - cyc0, 32'd16);
      chk("t5_cyc_low", {31'h0, wbm_cyc}, 32'h0);
      rd_chk("t5_errcnt", A_ERRC, 32'h0);

      // Abort during a long write phase; LEN writes while busy are ignored
      setup(32'h7, 32'h0000_1000, 32'd100);
      w0 = wlog_adr.size(); req0 = n_req; ack0 = n_ack;
      wbs_write(A_CTRL, 32'h1);
      repeat (10) @(negedge clk);
      wbs_write(A_LEN, 32'd5);
      wbs_write(A_CTRL, 32'h2);
      wait_done(1000);
      rd_chk("t6_status", A_STATUS, 32'h2);
      rd_chk("t6_len_kept", A_LEN, 32'd100);
      chk("t6_req_eq_ack", n_req - req0, n_ack - ack0);
      chk("t6_cut_short", 32'((wlog_adr.size() - w0) < 100), 32'h1);
      chk("t6_cyc_low", {31'h0, wbm_cyc}, 32'h0);

      // ABORT in IDLE is a no-op
      wbs_write(A_CTRL, 32'h2);
      rd_chk("t6_idle_abort", A_STATUS, 32'h2);

      // LEN=0: immediate pass, no bus traffic
      wbs_write(A_LEN, 32'd0);
      cyc0 = n_cyc; irq0 = n_irq;
      wbs_write(A_CTRL, 32'h1);
      wait_done(20);
      rd_chk("t7_status", A_STATUS, 32'h6);
      chk("t7_no_cyc", n_cyc - cyc0, 32'd0);
      chk("t7_irq", n_irq - irq0, 32'd1);
      rd_chk("t7_cycles", A_CYC, 32'h0);

      // Reset pulse mid-READ
      setup(32'h5, 32'h0000_2000, 32'd8);
      wbs_write(A_CTRL, 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (wbm_cyc && !wbm_we) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("t8_read_wait_timeout", 32'h0, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t8_cyc_async", {31'h0, wbm_cyc}, 32'h0);
      chk("t8_stb_async", {31'h0, wbm_stb}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int r = 0; r < 8; r++) begin
         rd_chk("t8_reg_zero", 3'(r), 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
